// File: rtl/cv32e40p_tb_test_ctrl.sv
// Boot-delay, run-cycle counter and sticky end-of-test verdict for the CV32E40P TB wrapper.
// Verdict registers one cycle after the event edge; no backpressure. Watchdog under TB_TEST_CTRL_WATCHDOG_EN.
module cv32e40p_tb_test_ctrl #(
    parameter int unsigned FETCH_DELAY    = 16,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             fetch_enable_o,
    input  logic             tests_passed_i,
    input  logic             tests_failed_i,
    input  logic             exit_valid_i,
    input  logic [31:0]      exit_value_i,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [31:0]      exit_code_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    localparam int unsigned DLY_W = (FETCH_DELAY > 1) ? $clog2(FETCH_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST =
        (FETCH_DELAY == 0) ? '0 : DLY_W'(FETCH_DELAY - 1);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be greater than zero");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DLY_W-1:0]   r_delay, w_delay_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic               r_fetch, w_fetch_nxt;
    logic               r_done,  w_done_nxt;
    logic               r_pass,  w_pass_nxt;
    logic               r_fail,  w_fail_nxt;
    logic               r_tmo,   w_tmo_nxt;
    logic [31:0]        r_code,  w_code_nxt;
    logic               w_boot_done;
    logic               w_wd_hit;

    assign w_boot_done = (FETCH_DELAY == 0) || (r_delay == DLY_LAST);

`ifdef TB_TEST_CTRL_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    assign w_wd_hit = (r_cnt == TIMEOUT_VAL);
`else
    assign w_wd_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_BOOT;
            r_delay <= '0;
            r_cnt   <= '0;
            r_fetch <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_tmo   <= 1'b0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_delay <= w_delay_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fetch <= w_fetch_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_fail  <= w_fail_nxt;
            r_tmo   <= w_tmo_nxt;
            r_code  <= w_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_delay_nxt = r_delay;
        w_cnt_nxt   = r_cnt;
        w_fetch_nxt = r_fetch;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_fail_nxt  = r_fail;
        w_tmo_nxt   = r_tmo;
        w_code_nxt  = r_code;
        unique case (r_state)
            ST_BOOT: begin
                w_delay_nxt = r_delay + DLY_W'(1);
                if (w_boot_done) begin
                    w_state_nxt = ST_RUN;
                    // count is 1 during the first RUN cycle
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_RUN: begin
                w_fetch_nxt = 1'b1;
                if (tests_failed_i) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_fail_nxt  = 1'b1;
                    w_code_nxt  = exit_valid_i ? exit_value_i : 32'h1;
                end else if (exit_valid_i) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (exit_value_i == 32'h0);
                    w_fail_nxt  = (exit_value_i != 32'h0);
                    w_code_nxt  = exit_value_i;
                end else if (tests_passed_i) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = 1'b1;
                    w_code_nxt  = 32'h0;
                end else if (w_wd_hit) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_fail_nxt  = 1'b1;
                    w_tmo_nxt   = 1'b1;
                    w_code_nxt  = 32'hFFFF_FFFF;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_fetch_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign fetch_enable_o = r_fetch;
    assign done_o         = r_done;
    assign pass_o         = r_pass;
    assign fail_o         = r_fail;
    assign exit_code_o    = r_code;
    assign cycle_count_o  = r_cnt;

`ifdef TB_TEST_CTRL_WATCHDOG_EN
    assign timeout_o = r_tmo;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_tb_test_ctrl.sv
// Scoreboard bench for cv32e40p_tb_test_ctrl: expected verdicts queued at stimulus, checked when done_o rises.
module tb_cv32e40p_tb_test_ctrl;

    localparam int unsigned FD = 16;
    localparam int unsigned CW = 32;
    localparam int unsigned TO = 600;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          fetch_enable_o;
    logic          tests_passed_i = 1'b0;
    logic          tests_failed_i = 1'b0;
    logic          exit_valid_i = 1'b0;
    logic [31:0]   exit_value_i = '0;
    logic          done_o, pass_o, fail_o, timeout_o;
    logic [31:0]   exit_code_o;
    logic [CW-1:0] cycle_count_o;

    cv32e40p_tb_test_ctrl #(
        .FETCH_DELAY    (FD),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .fetch_enable_o (fetch_enable_o),
        .tests_passed_i (tests_passed_i),
        .tests_failed_i (tests_failed_i),
        .exit_valid_i   (exit_valid_i),
        .exit_value_i   (exit_value_i),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .fail_o         (fail_o),
        .timeout_o      (timeout_o),
        .exit_code_o    (exit_code_o),
        .cycle_count_o  (cycle_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [31:0] code;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   run_cyc = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic f, input logic p, input logic v,
                                   input logic [31:0] val, input int n);
        exp_t e;
        e = '0;
        e.cnt = 32'(n);
        if (f) begin
            e.fail = 1'b1;
            e.code = v ? val : 32'h1;
        end else if (v) begin
            e.code = val;
            e.pass = (val == 32'h0);
            e.fail = (val != 32'h0);
        end else if (p) begin
            e.pass = 1'b1;
        end
        return e;
    endfunction

    // Verdict monitor: every rising done_o must match the oldest queued expectation
    always @(negedge clk_i) begin
        if (done_o && !prev_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done_o), 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pass", 32'(pass_o), 32'(mon_e.pass));
                chk("fail", 32'(fail_o), 32'(mon_e.fail));
                chk("timeout", 32'(timeout_o), 32'(mon_e.tmo));
                chk("exit_code", exit_code_o, mon_e.code);
                chk("cycle_count", cycle_count_o, mon_e.cnt);
            end
        end
        prev_done = done_o;
    end

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
        run_cyc++;
    endtask

    task automatic wait_sb(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) step();
        step();
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        sb_q.delete();
    endtask

    task automatic do_reset(input logic expect_fetch_was_on);
        @(negedge clk_i);
        rst_ni = 1'b0;
        tests_passed_i = 1'b0;
        tests_failed_i = 1'b0;
        exit_valid_i = 1'b0;
        exit_value_i = '0;
        #1;
        if (expect_fetch_was_on) chk("rst_async_fetch", 32'(fetch_enable_o), 32'h0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_fetch", 32'(fetch_enable_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_pass", 32'(pass_o), 32'h0);
        chk("rst_fail", 32'(fail_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        chk("rst_code", exit_code_o, 32'h0);
        chk("rst_cnt", cycle_count_o, 32'h0);
        rst_ni = 1'b1;
    endtask

    // Cycle 0 is the period right after release; RUN begins in cycle FD, fetch in FD+1
    task automatic boot_phase(input logic pulse_pass);
        for (int c = 0; c <= FD + 1; c++) begin
            if (c > 0) begin
                @(posedge clk_i);
                @(negedge clk_i);
            end
            chk($sformatf("fetch_c%0d", c), 32'(fetch_enable_o), (c >= FD + 1) ? 32'h1 : 32'h0);
            if (c == FD - 1) chk("cnt_last_boot", cycle_count_o, 32'h0);
            if (c == FD)     chk("cnt_first_run", cycle_count_o, 32'h1);
            tests_passed_i = (pulse_pass && c == 5);
        end
        tests_passed_i = 1'b0;
        chk("boot_no_done", 32'(done_o), 32'h0);
        run_cyc = 2;
    endtask

    task automatic test_event(input int n, input logic f, input logic p,
                              input logic v, input logic [31:0] val);
        while (run_cyc < n) step();
        tests_failed_i = f;
        tests_passed_i = p;
        exit_valid_i   = v;
        exit_value_i   = val;
        sb_q.push_back(model(f, p, v, val, n));
        step();
        tests_failed_i = 1'b0;
        tests_passed_i = 1'b0;
        exit_valid_i   = 1'b0;
        exit_value_i   = '0;
        wait_sb(8);
    endtask

    initial begin
        do_reset(1'b0);
        boot_phase(1'b1);
        test_event(500, 1'b0, 1'b0, 1'b1, 32'h0);
        tests_failed_i = 1'b1;
        step();
        tests_failed_i = 1'b0;
        repeat (3) step();
        chk("sticky_done", 32'(done_o), 32'h1);
        chk("sticky_pass", 32'(pass_o), 32'h1);
        chk("sticky_fail", 32'(fail_o), 32'h0);
        chk("sticky_code", exit_code_o, 32'h0);
        chk("sticky_cnt", cycle_count_o, 32'd500);
        chk("done_fetch", 32'(fetch_enable_o), 32'h1);

        do_reset(1'b1);
        boot_phase(1'b0);
        while (run_cyc < 20) step();
        chk("mid_run_cnt", cycle_count_o, 32'd20);
        do_reset(1'b1);
        boot_phase(1'b0);
        test_event(10, 1'b1, 1'b1, 1'b1, 32'h2A);

        do_reset(1'b1);
        boot_phase(1'b0);
        test_event(3, 1'b0, 1'b0, 1'b1, 32'h5);

        do_reset(1'b1);
        boot_phase(1'b0);
        test_event(2, 1'b0, 1'b1, 1'b0, 32'h0);

        do_reset(1'b1);
        boot_phase(1'b0);
        test_event(4, 1'b1, 1'b0, 1'b0, 32'h77);

        do_reset(1'b1);
        boot_phase(1'b0);
`ifdef TB_TEST_CTRL_WATCHDOG_EN
        sb_q.push_back('{pass: 1'b0, fail: 1'b1, tmo: 1'b1, code: 32'hFFFF_FFFF, cnt: 32'(TO)});
        wait_sb(TO + 20);
`else
        while (run_cyc < 700) step();
        chk("no_wd_done", 32'(done_o), 32'h0);
        chk("no_wd_timeout", 32'(timeout_o), 32'h0);
        chk("no_wd_cnt", cycle_count_o, 32'd700);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
